four_way_gf2_mul_seq: RTL and testbench

//  Parametrised sequential GF(2)[x] (carry-less) multiplier for N-bit binary-field operands.

---
 rtl/four_way_gf2_mul_seq_if.sv | 14 +
 rtl/four_way_gf2_mul_seq.sv | 118 +++++++++++
 tb/tb_four_way_gf2_mul_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/four_way_gf2_mul_seq_if.sv
// Start/busy/done handshake and operand/product bus for the sequential GF(2)[x] multiplier.
interface four_way_gf2_mul_seq_if #(
    parameter int unsigned N = 409
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] c;

    modport master (output start, a, b, input busy, done, c);
    modport slave  (input start, a, b, output busy, done, c);
endinterface

// File: rtl/four_way_gf2_mul_seq.sv
// Sequential carry-less multiplier: four-limb split, 16 digit-serial limb products,
// XOR-combined into the 2N-bit product in a final cycle.
module four_way_gf2_mul_seq #(
    parameter int unsigned N = 409,
    parameter int unsigned D = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    four_way_gf2_mul_seq_if.slave   bus
);
    localparam int unsigned K    = N / 4;
    localparam int unsigned L0   = N - 3 * K;
    localparam int unsigned ITER = (L0 + D - 1) / D;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam int unsigned AW   = 2 * L0;
    localparam int unsigned CN   = 2 * N;
    localparam int unsigned P [4] = '{0, L0, L0 + K, L0 + 2 * K};

    typedef enum logic [1:0] {IDLE, MUL, COMB} state_t;

    state_t          state, state_nx;
    logic [L0-1:0]   a_l  [4];
    logic [AW-1:0]   b_l  [4];
    logic [L0-1:0]   a_sh [4];
    logic [AW-1:0]   b_sh [4];
    logic [AW-1:0]   acc    [16];
    logic [AW-1:0]   acc_nx [16];
    logic [CW-1:0]   cnt;
    logic [CN-1:0]   c_nx;
    logic [CN-1:0]   c_q;
    logic            busy_q, done_q;
    logic            accept_c;

    assign accept_c = (state == IDLE) && bus.start;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;

    // Limb split; upper limbs zero-extended to the low-limb width.
    always_comb begin
        a_l[0] = bus.a[L0-1:0];
        b_l[0] = AW'(bus.b[L0-1:0]);
        for (int k = 1; k < 4; k++) begin
            a_l[k] = L0'(bus.a[P[k] +: K]);
            b_l[k] = AW'(bus.b[P[k] +: K]);
        end
    end

    // a limbs shift down and b limbs shift up by D each cycle, so the digit sits at bit 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc_nx[i*4+j] = acc[i*4+j];
                for (int t = 0; t < int'(D); t++) begin
                    if (a_sh[i][t]) acc_nx[i*4+j] = acc_nx[i*4+j] ^ (b_sh[j] << t);
                end
            end
        end
    end

    always_comb begin
        c_nx = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                c_nx = c_nx ^ (CN'(acc[i*4+j]) << (P[i] + P[j]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = MUL;
            MUL:     if (cnt == CW'(ITER - 1)) state_nx = COMB;
            COMB:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            c_q    <= '0;
            cnt    <= '0;
            for (int k = 0; k < 4; k++) begin
                a_sh[k] <= '0;
                b_sh[k] <= '0;
            end
            for (int k = 0; k < 16; k++) acc[k] <= '0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state == COMB);
            if (accept_c) begin
                cnt <= '0;
                for (int k = 0; k < 4; k++) begin
                    a_sh[k] <= a_l[k];
                    b_sh[k] <= b_l[k];
                end
                for (int k = 0; k < 16; k++) acc[k] <= '0;
            end else if (state == MUL) begin
                cnt <= cnt + CW'(1);
                for (int k = 0; k < 4; k++) begin
                    a_sh[k] <= a_sh[k] >> D;
                    b_sh[k] <= b_sh[k] << D;
                end
                for (int k = 0; k < 16; k++) acc[k] <= acc_nx[k];
            end else if (state == COMB) begin
                c_q <= c_nx;
            end
        end
    end
endmodule

// File: tb/tb_four_way_gf2_mul_seq.sv
// Directed, sequence and random checks of four_way_gf2_mul_seq in three configurations.
module tb_four_way_gf2_mul_seq;
    typedef logic [408:0] w_t;
    typedef logic [817:0] w2_t;
    typedef struct {
        string name;
        w_t    a;
        w_t    b;
        w2_t   c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    four_way_gf2_mul_seq_if #(.N(409)) if0 ();
    four_way_gf2_mul_seq_if #(.N(409)) if1 ();
    four_way_gf2_mul_seq_if #(.N(163)) if2 ();

    four_way_gf2_mul_seq #(.N(409), .D(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    four_way_gf2_mul_seq #(.N(409), .D(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    four_way_gf2_mul_seq #(.N(163), .D(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic w2_t ref_mul(input w_t a, input w_t b);
        w2_t r = '0;
        for (int i = 0; i < 409; i++) if (b[i]) r = r ^ (w2_t'(a) << i);
        return r;
    endfunction

    function automatic w_t rnd_w();
        w_t r = '0;
        for (int i = 0; i < 13; i++) r = (r << 32) | w_t'($urandom);
        return r;
    endfunction

    task automatic chk_w(input string nm, input w2_t act, input w2_t exp);
        int first = -1;
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 817; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            $display("FAIL %s: first differing bit %0d, got[127:0]=%h want[127:0]=%h",
                     nm, first, act[127:0], exp[127:0]);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One operation on dut0; returns product and cycles from accept edge to done.
    task automatic op0(input w_t a, input w_t b, output w2_t c, output int lat);
        @(negedge clk);
        if0.a = a; if0.b = b; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk_i("busy_after_accept", int'(if0.busy), 1);
        lat = 0;
        while (!if0.done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        c = if0.c;
        chk_i("busy_at_done", int'(if0.busy), 0);
    endtask

    task automatic op1(input w_t a, input w_t b, output w2_t c, output int lat);
        @(negedge clk);
        if1.a = a; if1.b = b; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        lat = 0;
        while (!if1.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        c = if1.c;
    endtask

    task automatic op2(input w_t a, input w_t b, output w2_t c, output int lat);
        @(negedge clk);
        if2.a = a[162:0]; if2.b = b[162:0]; if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        lat = 0;
        while (!if2.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        c = w2_t'(if2.c);
    endtask

    initial begin
        vec_t vt[7];
        w_t   ones, a1, b1, a2, b2, m163;
        w2_t  sq, c;
        int   lat, nd;

        ones = '1;
        sq   = '0;
        for (int k = 0; k < 409; k++) sq[2*k] = 1'b1;
        m163 = '0;
        for (int k = 0; k < 163; k++) m163[k] = 1'b1;
        vt[0] = '{"one_by_one",   w_t'(1),        w_t'(1),        w2_t'(1)};
        vt[1] = '{"three_sq",     w_t'(3),        w_t'(3),        w2_t'(5)};
        vt[2] = '{"five_by_three", w_t'(5),       w_t'(3),        w2_t'(15)};
        vt[3] = '{"zero_operand", w_t'(0),        ones,           w2_t'(0)};
        vt[4] = '{"limb_boundary", w_t'(1) << 102, w_t'(1) << 103, w2_t'(1) << 205};
        vt[5] = '{"top_bits",     w_t'(1) << 408, w_t'(1) << 408, w2_t'(1) << 816};
        vt[6] = '{"all_ones_sq",  ones,           ones,           sq};

        rst = 1'b0;
        if0.start = 1'b0; if0.a = '0; if0.b = '0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0;
        repeat (3) @(negedge clk);
        chk_i("reset_busy", int'(if0.busy), 0);
        chk_i("reset_done", int'(if0.done), 0);
        chk_w("reset_c", w2_t'(if0.c), '0);
        rst = 1'b1;

        foreach (vt[v]) begin
            op0(vt[v].a, vt[v].b, c, lat);
            chk_w(vt[v].name, c, vt[v].c);
            chk_i({vt[v].name, "_latency"}, lat, 104);
            @(negedge clk);
            chk_i({vt[v].name, "_pulse_width"}, int'(if0.done), 0);
        end

        // start held high with changing operands while busy, then back-to-back start in the done cycle
        a1 = rnd_w(); b1 = rnd_w(); a2 = rnd_w(); b2 = rnd_w();
        @(negedge clk);
        if0.a = a1; if0.b = b1; if0.start = 1'b1;
        lat = -1; nd = 0;
        while (!if0.done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (!if0.done) begin
                if0.a = rnd_w(); if0.b = rnd_w(); if0.start = 1'b1;
            end
        end
        chk_i("busy_start_latency", lat, 104);
        chk_w("busy_start_result", w2_t'(if0.c), ref_mul(a1, b1));
        if0.a = a2; if0.b = b2; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk_i("b2b_accepted", int'(if0.busy), 1);
        lat = 0;
        while (!if0.done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (if0.done) nd++;
        end
        chk_i("b2b_latency", lat, 104);
        chk_i("b2b_single_done", nd, 1);
        chk_w("b2b_result", w2_t'(if0.c), ref_mul(a2, b2));

        // reset in the middle of an operation
        @(negedge clk);
        if0.a = rnd_w(); if0.b = rnd_w(); if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_i("midreset_busy", int'(if0.busy), 0);
        chk_i("midreset_done", int'(if0.done), 0);
        chk_w("midreset_c", w2_t'(if0.c), '0);
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        repeat (120) begin
            @(negedge clk);
            if (if0.done) nd++;
        end
        chk_i("midreset_no_done", nd, 0);
        a1 = rnd_w(); b1 = rnd_w();
        op0(a1, b1, c, lat);
        chk_w("restart_result", c, ref_mul(a1, b1));
        chk_i("restart_latency", lat, 104);

        for (int r = 0; r < 60; r++) begin
            a1 = rnd_w(); b1 = rnd_w();
            op0(a1, b1, c, lat);
            chk_w("rand_n409_d1", c, ref_mul(a1, b1));
            chk_i("rand_n409_d1_latency", lat, 104);
        end
        for (int r = 0; r < 150; r++) begin
            a1 = rnd_w(); b1 = rnd_w();
            op1(a1, b1, c, lat);
            chk_w("rand_n409_d8", c, ref_mul(a1, b1));
            chk_i("rand_n409_d8_latency", lat, 14);
        end
        for (int r = 0; r < 150; r++) begin
            a1 = rnd_w() & m163; b1 = rnd_w() & m163;
            if (r == 0) begin a1 = m163; b1 = m163; end
            op2(a1, b1, c, lat);
            chk_w("rand_n163_d4", c, ref_mul(a1, b1));
            chk_i("rand_n163_d4_latency", lat, 12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
